// File: rtl/word_byte_serializer_if.sv
// Word-in / byte-out stream bundle for word_byte_serializer.
//   s_valid/s_ready/s_data : WIDTH-bit word handshake into the serializer
//   m_valid/m_ready/m_data/m_last : byte handshake out of the serializer
//   busy : serializer holds a word
// slave  = the serializer itself, master = the surrounding producer/consumer.
interface word_byte_serializer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [7:0]       m_data;
    logic             m_last;
    logic             busy;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last, busy
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last, busy
    );
endinterface

// File: rtl/word_byte_serializer.sv
// Accepts one WIDTH-bit word and emits it as bytes, LSB byte first, flagging
// the most significant byte with m_last.
//   clk : clock, all state updates on posedge
//   rst : synchronous active-high reset
//   bus : word_byte_serializer_if slave (word in, byte out, busy)
// s_ready is combinational from m_ready so a new word can be taken on the
// same edge the last byte of the previous word leaves (no bubble).
module word_byte_serializer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    word_byte_serializer_if.slave        bus
);

    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    // Reject widths that cannot be split into whole bytes.
    if ((WIDTH < 8) || ((WIDTH % 8) != 0)) begin : g_bad_width
        $error("word_byte_serializer: WIDTH must be a multiple of 8 and >= 8");
    end

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg,  sreg_nxt;
    logic [CW-1:0]    cnt,   cnt_nxt;
    logic [WIDTH-1:0] sreg_shift;

    logic             send;
    logic             last;
    logic             s_ready_int;

    // Next byte moves into the low lane; a single-byte word never shifts.
    if (BYTES > 1) begin : g_shift
        assign sreg_shift = {8'h00, sreg[WIDTH-1:8]};
    end else begin : g_noshift
        assign sreg_shift = '0;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: load, shift, or reload on the last byte.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.s_valid && s_ready_int) begin
                    sreg_nxt  = bus.s_data;
                    cnt_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.m_ready) begin
                    if (!last) begin
                        sreg_nxt = sreg_shift;
                        cnt_nxt  = cnt + CW'(1);
                    end else if (bus.s_valid && s_ready_int) begin
                        sreg_nxt = bus.s_data;
                        cnt_nxt  = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: byte lane and flags come straight from state; s_ready is the
    // only term that looks at a live input.
    always_comb begin
        send        = (state == SEND);
        last        = send && (cnt == CW'(BYTES - 1));
        s_ready_int = !rst && (!send || (bus.m_ready && last));

        bus.m_valid = send;
        bus.m_last  = last;
        bus.m_data  = sreg[7:0];
        bus.busy    = send;
        bus.s_ready = s_ready_int;
    end

endmodule
